// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requester agents and the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: none; ownership is sequenced by done and the hold timeout.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  // Requester side: drives requests and release, observes the grant.
  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  // Arbiter side: observes requests and release, drives the grant.
  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters share one resource, grant held until done/drop/timeout.
// Latency: req sampled at an edge produces a registered grant after that same edge (1 cycle).
// Backpressure: none; one idle turnaround cycle always separates consecutive grants.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  localparam int CW_RAW = $clog2(MAX_HOLD + 1);
  localparam int CW     = (CW_RAW > 5) ? CW_RAW : 5;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nx;
  logic [2:0]     ptr, ptr_nx;
  logic [2:0]     idx, idx_nx;
  logic [7:0]     grant, grant_nx;
  logic           valid, valid_nx;
  logic           tmo, tmo_nx;
  logic [CW-1:0]  cnt, cnt_nx;

  logic [2:0]     winner;
  logic           found;
  logic [2:0]     cand;
  logic           hold_hit;
  logic           owner_req;

  // Pick the first requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Hold limit reached on this edge (disabled when MAX_HOLD is 0).
  assign hold_hit  = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  assign owner_req = bus.req[idx];

  // Next-state and next-output logic; done beats drop beats timeout.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    grant_nx = grant;
    valid_nx = valid;
    tmo_nx   = 1'b0;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nx   = winner;
          grant_nx = 8'(1) << winner;
          valid_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (bus.done || !owner_req || hold_hit) begin
          // Release: grant_idx keeps the last owner, pointer moves past it.
          state_nx = IDLE;
          grant_nx = 8'h00;
          valid_nx = 1'b0;
          ptr_nx   = idx + 3'd1;
          tmo_nx   = !bus.done && owner_req && hold_hit;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      idx   <= 3'd0;
      grant <= 8'h00;
      valid <= 1'b0;
      tmo   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      idx   <= idx_nx;
      grant <= grant_nx;
      valid <= valid_nx;
      tmo   <= tmo_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = idx;
  assign bus.grant_valid = valid;
  assign bus.timeout     = tmo;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with MAX_HOLD=4.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_rr_arbiter8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       d;
    logic [7:0] eg;
    logic [2:0] ei;
    logic       ev;
    logic       et;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  // Drive inputs, take one edge, compare all outputs plus the one-hot invariant.
  task automatic step(input logic r, input logic [7:0] q, input logic d,
                      input logic [7:0] eg, input logic [2:0] ei,
                      input logic ev, input logic et, input string name);
    logic inv_ok;
    rst      = r;
    bus.req  = q;
    bus.done = d;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.grant !== eg || bus.grant_idx !== ei ||
        bus.grant_valid !== ev || bus.timeout !== et) begin
      n_fail++;
      $display("FAIL %s: got grant=%02h idx=%0d valid=%b timeout=%b, want grant=%02h idx=%0d valid=%b timeout=%b",
               name, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout, eg, ei, ev, et);
    end
    inv_ok = $onehot0(bus.grant) && (bus.grant_valid == (bus.grant != 8'h00)) &&
             (bus.grant == 8'h00 || bus.grant[bus.grant_idx]);
    n_checks++;
    if (!inv_ok) begin
      n_fail++;
      $display("FAIL %s_onehot: got grant=%02h idx=%0d valid=%b, want one-hot grant matching idx/valid",
               name, bus.grant, bus.grant_idx, bus.grant_valid);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    //           rst   req    done  grant  idx   valid timeout
    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // reset held
    vecs[2]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // single req
    vecs[3]  = '{1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // done -> ptr=1
    vecs[4]  = '{1'b0, 8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0}; // ptr 1 wins
    vecs[5]  = '{1'b0, 8'h03, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0}; // done -> ptr=2
    vecs[6]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // scan wraps to 0
    vecs[7]  = '{1'b0, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // done -> ptr=1
    vecs[8]  = '{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0}; // idx 7 wins
    vecs[9]  = '{1'b0, 8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0}; // done -> ptr wraps 0
    vecs[10] = '{1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // idx 0 after wrap
    vecs[11] = '{1'b0, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // owner drops -> ptr=1
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // idle, no req
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // done ignored in idle
    vecs[14] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0}; // grant idx 4
    vecs[15] = '{1'b1, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // reset mid-grant
    vecs[16] = '{1'b0, 8'h11, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // ptr back to 0
    vecs[17] = '{1'b0, 8'h11, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // done -> ptr=1
    vecs[18] = '{1'b0, 8'h11, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0}; // idx 4 wins
    vecs[19] = '{1'b0, 8'h1F, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0}; // other reqs ignored
    vecs[20] = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0}; // done -> ptr=5
    vecs[21] = '{1'b0, 8'hFF, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0}; // idx 5 wins

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].r, vecs[i].q, vecs[i].d, vecs[i].eg, vecs[i].ei,
           vecs[i].ev, vecs[i].et, $sformatf("vec%0d", i));
    end

    // Full rotation with all requesters active, released one cycle into each grant.
    step(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "rot_reset");
    for (int k = 0; k < 9; k++) begin
      logic [2:0] wi;
      wi = 3'(k % 8);
      step(1'b0, 8'hFF, 1'b0, 8'(1) << wi, wi, 1'b1, 1'b0, $sformatf("rot_grant%0d", k));
      step(1'b0, 8'hFF, 1'b1, 8'h00, wi, 1'b0, 1'b0, $sformatf("rot_gap%0d", k));
    end

    // Timeout: requester 0 holds for exactly 4 cycles, then requester 2 is served.
    step(1'b1, 8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "to_reset");
    for (int k = 0; k < 4; k++)
      step(1'b0, 8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, $sformatf("to_hold%0d", k));
    step(1'b0, 8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, "to_pulse");
    step(1'b0, 8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "to_next");
    step(1'b0, 8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "to_pulse_clear");

    // Done coinciding with the hold limit wins: no timeout pulse.
    step(1'b1, 8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "tod_reset");
    for (int k = 0; k < 4; k++)
      step(1'b0, 8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, $sformatf("tod_hold%0d", k));
    step(1'b0, 8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "tod_release");
    step(1'b0, 8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "tod_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
